cl_axi_reg_slice: RTL and testbench
===================================

CL_AXI_REG_SLICE -- requirements
Module: cl_axi_reg_slice

Interface
REQ-001 SHALL have parameter AW_EN, default 1, meaning 1 = register AW channel and 0 = combinational pass-through.
REQ-002 SHALL have parameter W_EN, default 1, with the same meaning for the W channel.
REQ-003 SHALL have parameter B_EN, default 1, with the same meaning for the B channel.
REQ-004 SHALL have parameter AR_EN, default 1, with the same meaning for the AR channel.
REQ-005 SHALL have parameter R_EN, default 1, with the same meaning for the R channel.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port s_axi_bus, axi_bus_t.master modport, interface: upstream side; the block receives AW/W/AR and drives B/R here.
REQ-009 SHALL have port m_axi_bus, axi_bus_t.slave modport, interface: downstream side; the block drives AW/W/AR and receives B/R here.
REQ-010 SHALL carry these fields per channel, at the widths defined by axi_bus_t:
- AW: awaddr, awid, awlen, awsize.
- W: wid, wdata, wstrb, wlast.
- B: bid, bresp.
- AR: araddr, arid, arlen, arsize.
- R: rid, rdata, rresp, rlast.

Function
REQ-011 SHALL implement each enabled channel as an independent 2-entry skid buffer (main register plus skid register) with a fully registered ready toward the producer.
REQ-012 SHALL forward payload bit-exact: no field is modified, dropped or reordered.
REQ-013 SHALL preserve per-channel beat order; channels are mutually unsynchronised and no cross-channel ordering is added.
REQ-014 SHALL have forward latency of exactly 1 cycle: a beat accepted at edge N is presented as valid downstream from edge N onward, i.e. visible in cycle N+1.
REQ-015 SHALL sustain one beat per cycle per channel when the consumer is always ready.
REQ-016 SHALL use per-channel states EMPTY, ONE and FULL.
REQ-017 SHALL make these transitions from EMPTY:
- producer handshake moves to ONE.
REQ-018 SHALL make these transitions from ONE:
- producer handshake with no consumer handshake moves to FULL.
- consumer handshake with no producer handshake moves to EMPTY.
- both handshakes stay in ONE with the main register reloaded.
REQ-019 SHALL make these transitions from FULL:
- consumer handshake moves the skid into main and enters ONE.
- no producer handshake is possible in FULL.
REQ-020 SHALL drive producer-side ready = 1 in EMPTY and ONE, and 0 in FULL, registered from next-state.
REQ-021 SHALL drive consumer-side valid = 1 in ONE and FULL, and present data from the main register.
REQ-022 SHALL hold consumer-side valid and payload stable while valid=1 and ready=0 (AXI rule); valid is never withdrawn without a handshake.
REQ-023 SHALL make a disabled channel (parameter 0) pure wires, with 0-cycle latency and no state.
REQ-024 SHALL never let valid depend combinationally on ready, nor ready on valid, on any enabled channel.

Reset
REQ-025 SHALL, while rst_n=0, force all channel states to EMPTY and drive every enabled-channel valid output (m awvalid/wvalid/arvalid, s bvalid/rvalid) to 0.
REQ-026 SHALL, while rst_n=0, drive every enabled-channel ready output to 0.
REQ-027 SHALL raise ready outputs to 1 on the first rising clk edge after rst_n deasserts.
REQ-028 SHALL leave payload registers unreset; they are don't-care while the corresponding valid=0.
REQ-029 SHALL, on assertion of rst_n mid-transfer, discard buffered beats immediately (asynchronous), with no output beat emitted afterward.

Verification
REQ-030 SHALL cover streaming: 16 AW beats awaddr=0x1000+64*i with m awready=1 constantly -> 16 beats out, same order, each 1 cycle later, s awready=1 throughout.
REQ-031 SHALL cover backpressure: W stream with m wready=0 for 3 cycles -> s wready falls to 0 after 2 beats accepted; after release, both beats plus subsequent ones exit in order, wdata/wstrb/wlast unchanged, none lost or duplicated.
REQ-032 SHALL cover a simultaneous event in ONE: rvalid/rready active on both sides in the same cycle -> state stays ONE, next R beat (rid=0x5, rlast=1) delivered next cycle.
REQ-033 SHALL cover reset mid-operation: AR slice FULL (arid 0x1, 0x2), drop rst_n -> m arvalid=0 and s arready=0 immediately; after release, no stale beat appears and arready=1 one edge later.
REQ-034 SHALL cover bypass: B_EN=0, bresp=2'b10, bid=0x7 -> appear on s_axi_bus in the same cycle; bready passes through combinationally.
REQ-035 SHALL cover random stall: random valid/ready on all 5 channels for 10k cycles -> a scoreboard matches every payload in order, and the AXI stability assertion (REQ-022) never fires.

Source files
------------

// File: rtl/cl_axi_reg_slice_if.sv
// AXI beat structs and the bus interface; modport names give the side the attached block
// faces (master = toward the AXI master, slave = toward the AXI slave).
package cl_axi_reg_slice_pkg;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
  } ax_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_t;
endpackage

interface axi_bus_t;
  import cl_axi_reg_slice_pkg::*;

  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [LEN_W-1:0]  awlen;
  logic [SIZE_W-1:0] awsize;

  logic              wvalid, wready;
  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;

  logic              bvalid, bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [LEN_W-1:0]  arlen;
  logic [SIZE_W-1:0] arsize;

  logic              rvalid, rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    input  awvalid, awaddr, awid, awlen, awsize, output awready,
    input  wvalid, wid, wdata, wstrb, wlast,     output wready,
    output bvalid, bid, bresp,                   input  bready,
    input  arvalid, araddr, arid, arlen, arsize, output arready,
    output rvalid, rid, rdata, rresp, rlast,     input  rready
  );

  modport slave (
    output awvalid, awaddr, awid, awlen, awsize, input  awready,
    output wvalid, wid, wdata, wstrb, wlast,     input  wready,
    input  bvalid, bid, bresp,                   output bready,
    output arvalid, araddr, arid, arlen, arsize, input  arready,
    input  rvalid, rid, rdata, rresp, rlast,     output rready
  );
endinterface

// File: rtl/cl_axi_reg_slice.sv
// Five-channel AXI register slice: each enabled channel is a 2-entry skid buffer, 1-cycle
// latency, full throughput; producer ready is a flop, so backpressure lands one beat late.
module cl_axi_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_dat_i,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic [W-1:0] out_dat_o
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e       state_q, state_d;
  logic         rdy_q, rdy_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_hs, out_hs;

  assign in_hs     = in_vld_i & rdy_q;
  assign out_hs    = (state_q != EMPTY) & out_rdy_i;
  assign in_rdy_o  = rdy_q;
  assign out_vld_o = (state_q != EMPTY);
  assign out_dat_o = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_hs) begin
          state_d = ONE;
          main_d  = in_dat_i;
        end
      end
      ONE: begin
        if (in_hs && !out_hs) begin
          state_d = FULL;
          skid_d  = in_dat_i;
        end else if (out_hs && !in_hs) begin
          state_d = EMPTY;
        end else if (in_hs && out_hs) begin
          main_d  = in_dat_i;
        end
      end
      FULL: begin
        // ready is low here, so only the consumer side can move
        if (out_hs) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    rdy_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end
endmodule

module cl_axi_reg_slice
  import cl_axi_reg_slice_pkg::*;
#(
  parameter bit AW_EN = 1'b1,
  parameter bit W_EN  = 1'b1,
  parameter bit B_EN  = 1'b1,
  parameter bit AR_EN = 1'b1,
  parameter bit R_EN  = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  axi_bus_t.master s_axi_bus,
  axi_bus_t.slave  m_axi_bus
);
  ax_t aw_in, aw_out, ar_in, ar_out;
  w_t  w_in, w_out;
  b_t  b_in, b_out;
  r_t  r_in, r_out;

  assign aw_in = {s_axi_bus.awaddr, s_axi_bus.awid, s_axi_bus.awlen, s_axi_bus.awsize};
  assign w_in  = {s_axi_bus.wid, s_axi_bus.wdata, s_axi_bus.wstrb, s_axi_bus.wlast};
  assign b_in  = {m_axi_bus.bid, m_axi_bus.bresp};
  assign ar_in = {s_axi_bus.araddr, s_axi_bus.arid, s_axi_bus.arlen, s_axi_bus.arsize};
  assign r_in  = {m_axi_bus.rid, m_axi_bus.rdata, m_axi_bus.rresp, m_axi_bus.rlast};

  assign {m_axi_bus.awaddr, m_axi_bus.awid, m_axi_bus.awlen, m_axi_bus.awsize} = aw_out;
  assign {m_axi_bus.wid, m_axi_bus.wdata, m_axi_bus.wstrb, m_axi_bus.wlast}    = w_out;
  assign {s_axi_bus.bid, s_axi_bus.bresp}                                      = b_out;
  assign {m_axi_bus.araddr, m_axi_bus.arid, m_axi_bus.arlen, m_axi_bus.arsize} = ar_out;
  assign {s_axi_bus.rid, s_axi_bus.rdata, s_axi_bus.rresp, s_axi_bus.rlast}    = r_out;

  generate
    if (AW_EN) begin : g_aw
      cl_axi_skid #(.W($bits(ax_t))) u_skid (
        .clk(clk), .rst_n(rst_n),
        .in_vld_i(s_axi_bus.awvalid), .in_rdy_o(s_axi_bus.awready), .in_dat_i(aw_in),
        .out_vld_o(m_axi_bus.awvalid), .out_rdy_i(m_axi_bus.awready), .out_dat_o(aw_out)
      );
    end else begin : g_aw_byp
      assign aw_out            = aw_in;
      assign m_axi_bus.awvalid = s_axi_bus.awvalid;
      assign s_axi_bus.awready = m_axi_bus.awready;
    end

    if (W_EN) begin : g_w
      cl_axi_skid #(.W($bits(w_t))) u_skid (
        .clk(clk), .rst_n(rst_n),
        .in_vld_i(s_axi_bus.wvalid), .in_rdy_o(s_axi_bus.wready), .in_dat_i(w_in),
        .out_vld_o(m_axi_bus.wvalid), .out_rdy_i(m_axi_bus.wready), .out_dat_o(w_out)
      );
    end else begin : g_w_byp
      assign w_out            = w_in;
      assign m_axi_bus.wvalid = s_axi_bus.wvalid;
      assign s_axi_bus.wready = m_axi_bus.wready;
    end

    // B and R flow slave-to-master, so the producer sits on m_axi_bus
    if (B_EN) begin : g_b
      cl_axi_skid #(.W($bits(b_t))) u_skid (
        .clk(clk), .rst_n(rst_n),
        .in_vld_i(m_axi_bus.bvalid), .in_rdy_o(m_axi_bus.bready), .in_dat_i(b_in),
        .out_vld_o(s_axi_bus.bvalid), .out_rdy_i(s_axi_bus.bready), .out_dat_o(b_out)
      );
    end else begin : g_b_byp
      assign b_out            = b_in;
      assign s_axi_bus.bvalid = m_axi_bus.bvalid;
      assign m_axi_bus.bready = s_axi_bus.bready;
    end

    if (AR_EN) begin : g_ar
      cl_axi_skid #(.W($bits(ax_t))) u_skid (
        .clk(clk), .rst_n(rst_n),
        .in_vld_i(s_axi_bus.arvalid), .in_rdy_o(s_axi_bus.arready), .in_dat_i(ar_in),
        .out_vld_o(m_axi_bus.arvalid), .out_rdy_i(m_axi_bus.arready), .out_dat_o(ar_out)
      );
    end else begin : g_ar_byp
      assign ar_out            = ar_in;
      assign m_axi_bus.arvalid = s_axi_bus.arvalid;
      assign s_axi_bus.arready = m_axi_bus.arready;
    end

    if (R_EN) begin : g_r
      cl_axi_skid #(.W($bits(r_t))) u_skid (
        .clk(clk), .rst_n(rst_n),
        .in_vld_i(m_axi_bus.rvalid), .in_rdy_o(m_axi_bus.rready), .in_dat_i(r_in),
        .out_vld_o(s_axi_bus.rvalid), .out_rdy_i(s_axi_bus.rready), .out_dat_o(r_out)
      );
    end else begin : g_r_byp
      assign r_out            = r_in;
      assign s_axi_bus.rvalid = m_axi_bus.rvalid;
      assign m_axi_bus.rready = s_axi_bus.rready;
    end
  endgenerate
endmodule

// File: tb/tb_cl_axi_reg_slice.sv
// Bench for cl_axi_reg_slice: per-channel FIFO model plus directed literal expectations.
module tb_cl_axi_reg_slice;
  import cl_axi_reg_slice_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_bus_t s_bus ();
  axi_bus_t m_bus ();
  axi_bus_t s2_bus ();
  axi_bus_t m2_bus ();

  cl_axi_reg_slice u_dut (.clk(clk), .rst_n(rst_n), .s_axi_bus(s_bus), .m_axi_bus(m_bus));
  cl_axi_reg_slice #(.B_EN(1'b0)) u_byp (.clk(clk), .rst_n(rst_n), .s_axi_bus(s2_bus), .m_axi_bus(m2_bus));

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: each enabled slice is a FIFO of depth 2, 1 cycle late ----------------
  localparam int NCH = 5;
  string       ch_nm [NCH] = '{"aw", "w", "b", "ar", "r"};
  logic [63:0] mq [NCH][4];
  int          mq_head [NCH];
  int          mq_cnt [NCH];
  int          n_in [NCH];
  int          n_out [NCH];
  logic        rdy_m [NCH];
  logic        hold [NCH];
  logic [63:0] prev [NCH];
  logic        in_v [NCH], in_r [NCH], out_v [NCH], out_r [NCH];
  logic [63:0] in_d [NCH], out_d [NCH];

  always @(negedge clk) begin
    in_v[0] = s_bus.awvalid;  in_r[0] = s_bus.awready;
    in_d[0] = 64'({s_bus.awaddr, s_bus.awid, s_bus.awlen, s_bus.awsize});
    out_v[0] = m_bus.awvalid; out_r[0] = m_bus.awready;
    out_d[0] = 64'({m_bus.awaddr, m_bus.awid, m_bus.awlen, m_bus.awsize});
    in_v[1] = s_bus.wvalid;   in_r[1] = s_bus.wready;
    in_d[1] = 64'({s_bus.wid, s_bus.wdata, s_bus.wstrb, s_bus.wlast});
    out_v[1] = m_bus.wvalid;  out_r[1] = m_bus.wready;
    out_d[1] = 64'({m_bus.wid, m_bus.wdata, m_bus.wstrb, m_bus.wlast});
    in_v[2] = m_bus.bvalid;   in_r[2] = m_bus.bready;
    in_d[2] = 64'({m_bus.bid, m_bus.bresp});
    out_v[2] = s_bus.bvalid;  out_r[2] = s_bus.bready;
    out_d[2] = 64'({s_bus.bid, s_bus.bresp});
    in_v[3] = s_bus.arvalid;  in_r[3] = s_bus.arready;
    in_d[3] = 64'({s_bus.araddr, s_bus.arid, s_bus.arlen, s_bus.arsize});
    out_v[3] = m_bus.arvalid; out_r[3] = m_bus.arready;
    out_d[3] = 64'({m_bus.araddr, m_bus.arid, m_bus.arlen, m_bus.arsize});
    in_v[4] = m_bus.rvalid;   in_r[4] = m_bus.rready;
    in_d[4] = 64'({m_bus.rid, m_bus.rdata, m_bus.rresp, m_bus.rlast});
    out_v[4] = s_bus.rvalid;  out_r[4] = s_bus.rready;
    out_d[4] = 64'({s_bus.rid, s_bus.rdata, s_bus.rresp, s_bus.rlast});

    for (int c = 0; c < NCH; c++) begin
      if (!rst_n) begin
        check({ch_nm[c], "_rst_vld"}, 64'(out_v[c]), 64'd0);
        check({ch_nm[c], "_rst_rdy"}, 64'(in_r[c]), 64'd0);
        mq_cnt[c] = 0; mq_head[c] = 0; rdy_m[c] = 1'b0; hold[c] = 1'b0;
      end else begin
        check({ch_nm[c], "_vld"}, 64'(out_v[c]), 64'(mq_cnt[c] != 0));
        if (mq_cnt[c] != 0) check({ch_nm[c], "_dat"}, out_d[c], mq[c][mq_head[c]]);
        check({ch_nm[c], "_rdy"}, 64'(in_r[c]), 64'(rdy_m[c]));
        if (hold[c]) begin
          check({ch_nm[c], "_stable_vld"}, 64'(out_v[c]), 64'd1);
          check({ch_nm[c], "_stable_dat"}, out_d[c], prev[c]);
        end
        hold[c] = out_v[c] && !out_r[c];
        prev[c] = out_d[c];
        if (out_v[c] && out_r[c] && mq_cnt[c] > 0) begin
          mq_head[c] = (mq_head[c] + 1) % 4;
          mq_cnt[c]--;
          n_out[c]++;
        end
        if (in_v[c] && in_r[c]) begin
          n_in[c]++;
          if (mq_cnt[c] < 4) begin
            mq[c][(mq_head[c] + mq_cnt[c]) % 4] = in_d[c];
            mq_cnt[c]++;
          end else begin
            check({ch_nm[c], "_overflow"}, 64'(mq_cnt[c]), 64'd3);
          end
        end
        rdy_m[c] = (mq_cnt[c] < 2);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_w(input int b);
    logic acc = 1'b0;
    s_bus.wvalid = 1'b1;
    s_bus.wid    = 4'(b);
    s_bus.wdata  = 32'hA000_0000 + 32'(b) * 32'h111;
    s_bus.wstrb  = 4'(15 - b);
    s_bus.wlast  = (b == 5);
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = s_bus.wready;
      @(posedge clk); #1;
    end
    check("w_accept", 64'(acc), 64'd1);
  endtask

  task automatic rand_phase(input int n);
    logic acc [NCH];
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      acc[0] = s_bus.awvalid && s_bus.awready;
      acc[1] = s_bus.wvalid && s_bus.wready;
      acc[2] = m_bus.bvalid && m_bus.bready;
      acc[3] = s_bus.arvalid && s_bus.arready;
      acc[4] = m_bus.rvalid && m_bus.rready;
      @(posedge clk); #1;
      if (!s_bus.awvalid || acc[0]) begin
        s_bus.awvalid = ($urandom_range(0, 3) != 0);
        {s_bus.awaddr, s_bus.awid, s_bus.awlen, s_bus.awsize} = 47'({$urandom(), $urandom()});
      end
      if (!s_bus.wvalid || acc[1]) begin
        s_bus.wvalid = ($urandom_range(0, 3) != 0);
        {s_bus.wid, s_bus.wdata, s_bus.wstrb, s_bus.wlast} = 41'({$urandom(), $urandom()});
      end
      if (!m_bus.bvalid || acc[2]) begin
        m_bus.bvalid = ($urandom_range(0, 3) != 0);
        {m_bus.bid, m_bus.bresp} = 6'($urandom());
      end
      if (!s_bus.arvalid || acc[3]) begin
        s_bus.arvalid = ($urandom_range(0, 3) != 0);
        {s_bus.araddr, s_bus.arid, s_bus.arlen, s_bus.arsize} = 47'({$urandom(), $urandom()});
      end
      if (!m_bus.rvalid || acc[4]) begin
        m_bus.rvalid = ($urandom_range(0, 3) != 0);
        {m_bus.rid, m_bus.rdata, m_bus.rresp, m_bus.rlast} = 39'({$urandom(), $urandom()});
      end
      m_bus.awready = 1'($urandom());
      m_bus.wready  = 1'($urandom());
      s_bus.bready  = 1'($urandom());
      m_bus.arready = 1'($urandom());
      s_bus.rready  = 1'($urandom());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    for (int c = 0; c < NCH; c++) begin
      mq_cnt[c] = 0; mq_head[c] = 0; n_in[c] = 0; n_out[c] = 0;
      rdy_m[c] = 1'b0; hold[c] = 1'b0; prev[c] = '0;
    end
    rst_n = 1'b0;
    s_bus.awvalid = 0; s_bus.awaddr = 0; s_bus.awid = 0; s_bus.awlen = 0; s_bus.awsize = 0;
    s_bus.wvalid = 0; s_bus.wid = 0; s_bus.wdata = 0; s_bus.wstrb = 0; s_bus.wlast = 0;
    s_bus.arvalid = 0; s_bus.araddr = 0; s_bus.arid = 0; s_bus.arlen = 0; s_bus.arsize = 0;
    s_bus.bready = 1; s_bus.rready = 1;
    m_bus.awready = 1; m_bus.wready = 1; m_bus.arready = 1;
    m_bus.bvalid = 0; m_bus.bid = 0; m_bus.bresp = 0;
    m_bus.rvalid = 0; m_bus.rid = 0; m_bus.rdata = 0; m_bus.rresp = 0; m_bus.rlast = 0;
    s2_bus.awvalid = 0; s2_bus.awaddr = 0; s2_bus.awid = 0; s2_bus.awlen = 0; s2_bus.awsize = 0;
    s2_bus.wvalid = 0; s2_bus.wid = 0; s2_bus.wdata = 0; s2_bus.wstrb = 0; s2_bus.wlast = 0;
    s2_bus.arvalid = 0; s2_bus.araddr = 0; s2_bus.arid = 0; s2_bus.arlen = 0; s2_bus.arsize = 0;
    s2_bus.bready = 0; s2_bus.rready = 0;
    m2_bus.awready = 0; m2_bus.wready = 0; m2_bus.arready = 0;
    m2_bus.bvalid = 0; m2_bus.bid = 0; m2_bus.bresp = 0;
    m2_bus.rvalid = 0; m2_bus.rid = 0; m2_bus.rdata = 0; m2_bus.rresp = 0; m2_bus.rlast = 0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 64'(s_bus.awready), 64'd0);
    check("rst_wready", 64'(s_bus.wready), 64'd0);
    check("rst_bready", 64'(m_bus.bready), 64'd0);
    check("rst_awvalid", 64'(m_bus.awvalid), 64'd0);
    check("rst_rvalid", 64'(s_bus.rvalid), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_arready_before_edge", 64'(s_bus.arready), 64'd0);
    @(posedge clk); #1;
    check("rel_arready_after_edge", 64'(s_bus.arready), 64'd1);
    check("rel_rready_after_edge", 64'(m_bus.rready), 64'd1);

    // AW streaming
    for (int i = 0; i < 16; i++) begin
      s_bus.awvalid = 1'b1;
      s_bus.awaddr  = 32'h1000 + 32'(64 * i);
      s_bus.awid    = 4'(i);
      @(negedge clk);
      if (i > 0) check("stream_awaddr", 64'(m_bus.awaddr), 64'(32'h1000 + 64 * (i - 1)));
      check("stream_awready", 64'(s_bus.awready), 64'd1);
      @(posedge clk); #1;
    end
    s_bus.awvalid = 1'b0;
    @(negedge clk);
    check("stream_awaddr_last", 64'(m_bus.awaddr), 64'h13C0);
    check("stream_awvalid_last", 64'(m_bus.awvalid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("stream_awvalid_idle", 64'(m_bus.awvalid), 64'd0);
    @(posedge clk); #1;

    // W backpressure
    m_bus.wready = 1'b0;
    fork
      begin
        for (int b = 0; b < 6; b++) send_w(b);
        s_bus.wvalid = 1'b0;
      end
      begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("bp_wready_low", 64'(s_bus.wready), 64'd0);
        check("bp_wdata0", 64'(m_bus.wdata), 64'hA000_0000);
        check("bp_wstrb0", 64'(m_bus.wstrb), 64'hF);
        @(posedge clk); #1 m_bus.wready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("bp_wdata1", 64'(m_bus.wdata), 64'hA000_0111);
        check("bp_wready_up", 64'(s_bus.wready), 64'd1);
      end
    join
    repeat (3) begin @(posedge clk); #1; end
    check("bp_w_count", 64'(n_out[1]), 64'd6);

    // R simultaneous handshakes in ONE
    s_bus.rready = 1'b1;
    m_bus.rvalid = 1'b1; m_bus.rid = 4'h4; m_bus.rdata = 32'hDEAD_0004; m_bus.rresp = 2'b00; m_bus.rlast = 1'b0;
    @(posedge clk); #1;
    m_bus.rid = 4'h5; m_bus.rdata = 32'hDEAD_0005; m_bus.rlast = 1'b1;
    @(negedge clk);
    check("r_one_vld", 64'(s_bus.rvalid), 64'd1);
    check("r_one_rid", 64'(s_bus.rid), 64'h4);
    check("r_one_rready", 64'(m_bus.rready), 64'd1);
    @(posedge clk); #1;
    m_bus.rvalid = 1'b0;
    @(negedge clk);
    check("r_both_rid", 64'(s_bus.rid), 64'h5);
    check("r_both_rlast", 64'(s_bus.rlast), 64'd1);
    check("r_both_rdata", 64'(s_bus.rdata), 64'hDEAD_0005);
    check("r_both_rready", 64'(m_bus.rready), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("r_drained", 64'(s_bus.rvalid), 64'd0);
    @(posedge clk); #1;

    // AR reset mid-operation
    m_bus.arready = 1'b0;
    s_bus.arvalid = 1'b1; s_bus.arid = 4'h1; s_bus.araddr = 32'h2000;
    @(posedge clk); #1;
    s_bus.arid = 4'h2; s_bus.araddr = 32'h2040;
    @(posedge clk); #1;
    s_bus.arvalid = 1'b0;
    @(negedge clk);
    check("ar_full_rdy", 64'(s_bus.arready), 64'd0);
    check("ar_full_arid", 64'(m_bus.arid), 64'h1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("ar_rst_arvalid", 64'(m_bus.arvalid), 64'd0);
    check("ar_rst_arready", 64'(s_bus.arready), 64'd0);
    m_bus.arready = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("ar_rel_arready", 64'(s_bus.arready), 64'd0);
    @(posedge clk); #1;
    check("ar_up_arready", 64'(s_bus.arready), 64'd1);
    check("ar_no_stale", 64'(m_bus.arvalid), 64'd0);
    @(posedge clk); #1;

    // B bypass instance
    m2_bus.bvalid = 1'b1; m2_bus.bid = 4'h7; m2_bus.bresp = 2'b10;
    #1;
    check("byp_bvalid", 64'(s2_bus.bvalid), 64'd1);
    check("byp_bid", 64'(s2_bus.bid), 64'h7);
    check("byp_bresp", 64'(s2_bus.bresp), 64'h2);
    s2_bus.bready = 1'b1;
    #1;
    check("byp_bready_hi", 64'(m2_bus.bready), 64'd1);
    s2_bus.bready = 1'b0; m2_bus.bvalid = 1'b0;
    #1;
    check("byp_bready_lo", 64'(m2_bus.bready), 64'd0);
    check("byp_bvalid_lo", 64'(s2_bus.bvalid), 64'd0);
    @(posedge clk); #1;

    // random stall on all channels
    for (int c = 0; c < NCH; c++) begin n_in[c] = 0; n_out[c] = 0; end
    rand_phase(10000);
    s_bus.awvalid = 0; s_bus.wvalid = 0; s_bus.arvalid = 0; m_bus.bvalid = 0; m_bus.rvalid = 0;
    m_bus.awready = 1; m_bus.wready = 1; m_bus.arready = 1; s_bus.bready = 1; s_bus.rready = 1;
    repeat (5) begin @(posedge clk); #1; end
    for (int c = 0; c < NCH; c++) check({ch_nm[c], "_beats_out_eq_in"}, 64'(n_out[c]), 64'(n_in[c]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
